// File: rtl/fp8_addsub_seq.sv
// Multi-cycle FP8 (1.3.4) add/subtract sequencer with start/busy/done handshake.
// Aligns one shift per cycle, adds magnitudes, normalizes one shift per cycle.
module fp8_addsub_seq #(
  parameter int EARLY_EXIT = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic [7:0] A,
  input  logic [7:0] B,
  input  logic       funct,
  output logic       busy,
  output logic       done,
  output logic [7:0] Y,
  output logic       zero,
  output logic       ovf
);

  typedef enum logic [2:0] {IDLE, ALIGN, ADD, NORM, DONE} state_t;

  state_t     state_reg;
  logic       busy_reg, done_reg, zero_reg, ovf_reg;
  logic [7:0] y_reg;
  logic       sa_reg, sb_reg, sign_reg;
  logic [2:0] ea_reg, eb_reg, e_reg;
  logic [5:0] ma_reg, mb_reg, sum_reg;
  logic       ovf_pend_reg, flush_pend_reg;

  logic       a_zero, b_zero, early_flush;
  logic [2:0] exp_diff;
  logic [7:0] norm_y;

  assign a_zero      = (A[6:0] == 7'd0);
  assign b_zero      = (B[6:0] == 7'd0);
  assign exp_diff    = (ea_reg > eb_reg) ? (ea_reg - eb_reg) : (eb_reg - ea_reg);
  assign early_flush = (EARLY_EXIT != 0) && (exp_diff > 3'd5);
  assign norm_y      = {sign_reg, e_reg, sum_reg[3:0]};

  assign busy = busy_reg;
  assign done = done_reg;
  assign Y    = y_reg;
  assign zero = zero_reg;
  assign ovf  = ovf_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg      <= IDLE;
      busy_reg       <= 1'b0;
      done_reg       <= 1'b0;
      y_reg          <= 8'h00;
      zero_reg       <= 1'b1;
      ovf_reg        <= 1'b0;
      sa_reg         <= 1'b0;
      sb_reg         <= 1'b0;
      sign_reg       <= 1'b0;
      ea_reg         <= 3'd0;
      eb_reg         <= 3'd0;
      e_reg          <= 3'd0;
      ma_reg         <= 6'd0;
      mb_reg         <= 6'd0;
      sum_reg        <= 6'd0;
      ovf_pend_reg   <= 1'b0;
      flush_pend_reg <= 1'b0;
    end else begin
      done_reg <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (start) begin
            busy_reg       <= 1'b1;
            ovf_pend_reg   <= 1'b0;
            flush_pend_reg <= 1'b0;
            sa_reg         <= A[7];
            sb_reg         <= B[7] ^ funct;
            ea_reg         <= A[6:4];
            eb_reg         <= B[6:4];
            ma_reg         <= {2'b01, A[3:0]};
            mb_reg         <= {2'b01, B[3:0]};
            if (a_zero || b_zero) begin
              // Zero operand: the result is simply the other operand.
              state_reg <= DONE;
              done_reg  <= 1'b1;
              ovf_reg   <= 1'b0;
              if (a_zero && b_zero) begin
                y_reg    <= 8'h00;
                zero_reg <= 1'b1;
              end else if (a_zero) begin
                y_reg    <= {B[7] ^ funct, B[6:0]};
                zero_reg <= 1'b0;
              end else begin
                y_reg    <= A;
                zero_reg <= 1'b0;
              end
            end else begin
              state_reg <= ALIGN;
            end
          end
        end

        ALIGN: begin
          if (ea_reg == eb_reg) begin
            state_reg <= ADD;
          end else if (early_flush) begin
            state_reg <= ADD;
            if (ea_reg < eb_reg) begin
              ma_reg <= 6'd0;
              ea_reg <= eb_reg;
            end else begin
              mb_reg <= 6'd0;
              eb_reg <= ea_reg;
            end
          end else if (ea_reg < eb_reg) begin
            ma_reg <= ma_reg >> 1;
            ea_reg <= ea_reg + 3'd1;
          end else begin
            mb_reg <= mb_reg >> 1;
            eb_reg <= eb_reg + 3'd1;
          end
        end

        ADD: begin
          state_reg <= NORM;
          e_reg     <= ea_reg;
          if (sa_reg == sb_reg) begin
            sum_reg  <= ma_reg + mb_reg;
            sign_reg <= sa_reg;
          end else if (ma_reg > mb_reg) begin
            sum_reg  <= ma_reg - mb_reg;
            sign_reg <= sa_reg;
          end else if (mb_reg > ma_reg) begin
            sum_reg  <= mb_reg - ma_reg;
            sign_reg <= sb_reg;
          end else begin
            sum_reg  <= 6'd0;
            sign_reg <= 1'b0;
          end
        end

        NORM: begin
          // Out-of-range shifts are taken as a shift step, then resolved next cycle.
          if (ovf_pend_reg) begin
            state_reg <= DONE;
            done_reg  <= 1'b1;
            y_reg     <= {sign_reg, 3'b111, 4'b1111};
            zero_reg  <= 1'b0;
            ovf_reg   <= 1'b1;
          end else if (flush_pend_reg || (sum_reg == 6'd0)) begin
            state_reg <= DONE;
            done_reg  <= 1'b1;
            y_reg     <= 8'h00;
            zero_reg  <= 1'b1;
            ovf_reg   <= 1'b0;
          end else if (sum_reg[5]) begin
            sum_reg <= sum_reg >> 1;
            if (e_reg == 3'd7) ovf_pend_reg <= 1'b1;
            else               e_reg        <= e_reg + 3'd1;
          end else if (!sum_reg[4]) begin
            sum_reg <= sum_reg << 1;
            if (e_reg == 3'd0) flush_pend_reg <= 1'b1;
            else               e_reg          <= e_reg - 3'd1;
          end else begin
            state_reg <= DONE;
            done_reg  <= 1'b1;
            y_reg     <= norm_y;
            zero_reg  <= (norm_y == 8'h00);
            ovf_reg   <= 1'b0;
          end
        end

        DONE: begin
          state_reg <= IDLE;
          busy_reg  <= 1'b0;
        end

        default: begin
          state_reg <= IDLE;
          busy_reg  <= 1'b0;
        end
      endcase
    end
  end

endmodule
